// File: rtl/handshake_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter feeding the skid FIFO.
// The default widths here fix the layout of entry_t, so the top-level parameters must match them.
package handshake_arb_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_DEPTH   = 2;
    localparam int MAX_REQ     = 8;

    localparam int ID_W  = $clog2(DEF_NUM_REQ);
    localparam int CNT_W = $clog2(DEF_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] in1;
        logic [DEF_WIDTH-1:0] in2;
        logic [ID_W-1:0]      id;
    } entry_t;

    // Searches from ptr+1 upward, wrapping modulo n, and returns a one-hot grant.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        logic [3:0]         pos;
        logic [2:0]         sel;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            pos = {1'b0, ptr} + 4'(k);
            if (pos >= 4'(n)) begin
                pos = pos - 4'(n);
            end
            sel = pos[2:0];
            if (k <= n && !found && valid[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its encoded index.
module rr_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        pick                   = rr_pick(req_ext, 3'(rr_ptr), NUM_REQ);
        grant                  = enable ? pick[NUM_REQ-1:0] : '0;
        grant_idx              = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Lanes above NUM_REQ can never be granted since their requests are tied low.
    assign unused_pick = ^pick;

endmodule

// File: rtl/handshake_arb_skid.sv
// Round-robin arbitration of NUM_REQ operand-pair requesters into a small skid FIFO,
// whose head is presented downstream as a single ready/valid stream.
module handshake_arb_skid
    import handshake_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [NUM_REQ-1:0]       handshake_arr_valid,
    output logic [NUM_REQ-1:0]       handshake_arr_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    output logic                     handshake_valid,
    input  logic                     handshake_ready,
    output logic [WIDTH-1:0]         in1,
    output logic [WIDTH-1:0]         in2,
    output logic [ID_W-1:0]          src_id,
    output logic [CNT_W-1:0]         occupancy
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ID_W-1:0]  LAST_REQ = ID_W'(NUM_REQ - 1);

    logic [WIDTH-1:0] req_in1_arr [NUM_REQ];
    logic [WIDTH-1:0] req_in2_arr [NUM_REQ];

    entry_t           mem [DEPTH];
    entry_t           last_pop_reg;
    entry_t           head;
    entry_t           push_entry;

    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [ID_W-1:0]  rr_ptr_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               can_push;
    logic               push;
    logic               pop;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_in1_arr[gi] = req_in1[gi*WIDTH +: WIDTH];
        assign req_in2_arr[gi] = req_in2[gi*WIDTH +: WIDTH];
    end

    // Acceptance depends only on registered count, so no ready path runs
    // combinationally from handshake_ready back to the requesters.
    assign can_push = (count_reg < FULL_CNT);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req       (handshake_arr_valid),
        .rr_ptr    (rr_ptr_reg),
        .enable    (can_push & ~RESET),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign handshake_arr_ready = grant;
    assign push                = |grant;
    assign handshake_valid     = (count_reg != '0) & ~RESET;
    assign pop                 = handshake_valid & handshake_ready;

    always_comb begin
        push_entry.in1 = req_in1_arr[grant_idx];
        push_entry.in2 = req_in2_arr[grant_idx];
        push_entry.id  = grant_idx;
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            rr_ptr_reg   <= LAST_REQ;
            last_pop_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                rr_ptr_reg <= grant_idx;
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                last_pop_reg <= mem[rd_ptr_reg];
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // When empty the outputs keep showing the most recently popped entry.
    assign head = (count_reg != '0) ? mem[rd_ptr_reg] : last_pop_reg;

    always_comb begin
        in1       = '0;
        in2       = '0;
        src_id    = '0;
        occupancy = '0;
        if (!RESET) begin
            in1       = head.in1;
            in2       = head.in2;
            src_id    = head.id;
            occupancy = count_reg;
        end
    end

endmodule

// File: doc/handshake_arb_skid.md
Name: handshake_arb_skid

Overview:
- Upstream feeder for the reduction datapath whose in1/in2/handshake ports are checked by the RTL monitor.
- Round-robin arbitrates NUM_REQ requesters, each carrying an in1/in2 operand pair, into a 2-entry skid FIFO.
- Presents the FIFO head to the downstream stage as a single ready/valid stream: in1, in2, handshake_valid/handshake_ready.
- The per-requester handshakes are the handshake_arr_N_valid/ready pairs the monitor observes.

Parameters:
- WIDTH, 4, operand width of in1/in2
- NUM_REQ, 3, number of upstream requesters (2..8)
- DEPTH, 2, skid FIFO entries (power of two, >=2)

Ports:
- CLK  input  1  clock, all state on posedge
- RESET  input  1  synchronous active-high reset
- handshake_arr_valid  input  NUM_REQ  per-requester valid
- handshake_arr_ready  output  NUM_REQ  per-requester ready (one-hot or zero)
- req_in1  input  NUM_REQ*WIDTH  requester operand 1, slice i = requester i
- req_in2  input  NUM_REQ*WIDTH  requester operand 2
- handshake_valid  output  1  downstream valid
- handshake_ready  input  1  downstream ready
- in1  output  WIDTH  head operand 1
- in2  output  WIDTH  head operand 2
- src_id  output  clog2(NUM_REQ)  requester index of head entry
- occupancy  output  clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset, synchronous, while RESET=1 at posedge:
  - count=0, rd/wr pointers=0, rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - While RESET is high: handshake_arr_ready=0, handshake_valid=0, in1=in2=0, src_id=0, occupancy=0.
  - Mid-operation reset discards all entries; no partial transfer completes in that cycle.
- Arbitration (combinational):
  - Search from rr_ptr+1 upward, wrapping modulo NUM_REQ; the first asserted valid wins.
  - Grant is one-hot.
  - handshake_arr_ready[i] = grant[i] & (count<DEPTH) & !RESET.
  - Ready depends only on registered count, never on handshake_ready; there is no combinational ready path through the block.
- Push: when the granted requester's valid&ready is high at posedge, write {req_in1[i], req_in2[i], i} at wr_ptr and set rr_ptr=i. rr_ptr is unchanged when nothing is accepted.
- Pop: handshake_valid = (count!=0). When handshake_valid & handshake_ready at posedge, advance rd_ptr.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count==DEPTH): no push, even if a pop occurs in the same cycle. A new push is possible the cycle after the pop.
- Empty: handshake_valid=0; in1/in2/src_id hold the last popped entry (0 after reset).
- Latency: accepted in cycle N gives handshake_valid in cycle N+1 when the FIFO was empty. Throughput is 1 transfer/cycle while downstream is ready.
- Outputs in1, in2, src_id are driven from the FIFO storage at rd_ptr (registered data, no combinational input-to-output path).
- Payload stability: while handshake_valid=1 and handshake_ready=0, in1/in2/src_id hold stable and handshake_valid stays high.
- Pointer and ordering rules: pointers wrap modulo DEPTH. The valid input from a requester may drop without a transfer; the arbiter simply re-evaluates.
- Fairness: with all NUM_REQ requesters continuously valid and the FIFO draining, grants rotate 0,1,…,NUM_REQ-1,0.
- occupancy = count.

Decomposition:
- Package handshake_arb_pkg:
  - localparams ID_W = clog2(NUM_REQ) and CNT_W.
  - Packed struct entry_t {logic [WIDTH-1:0] in1, in2; logic [ID_W-1:0] id}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-module rr_arbiter: request vector, rr_ptr and enable in; one-hot grant and index out; purely combinational. The FIFO stays inline in the top level.

Test Plan:
- Reset: hold RESET 3 cycles with all valids=1 -> handshake_arr_ready=000, handshake_valid=0, in1=in2=0, occupancy=0. Release -> the next cycle grants requester 0 (ready=001).
- Single transfer: requester 1 valid, in1=4'hA, in2=4'h5, handshake_ready=1 -> accepted cycle N; cycle N+1 handshake_valid=1, in1=A, in2=5, src_id=1; cycle N+2 handshake_valid=0.
- Round-robin: all three valid with distinct payloads, handshake_ready=1 -> downstream src_id sequence 0,1,2,0,1,2 with no bubbles after the first entry.
- Backpressure/full: handshake_ready=0, requester 2 valid -> two pushes, occupancy=2, handshake_arr_ready=000. Payload is stable for 5 cycles. Raise ready -> entries pop in order. The first push after the pop lands one cycle later.
- Simultaneous push/pop at count=1: occupancy stays 1 across 4 cycles and the output order matches the accept order.
- Mid-operation reset: occupancy=2, assert RESET for 1 cycle -> next cycle handshake_valid=0, occupancy=0, and the next grant goes to requester 0.
